product_accumulator: RTL and testbench

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/product_accumulator.sv | 105 ++++++++++
 tb/tb_product_accumulator.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Sum-of-products accumulator: a run of len 4x4-bit products is summed into an
// ACC_W-bit wrapping accumulator with a sticky overflow flag, then handed off.
module product_accumulator #(
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [4:0]       len_q, len_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;

  logic [7:0]       product;
  logic [ACC_W:0]   acc_sum;

  assign product = {4'b0000, a} * {4'b0000, b};
  // One extra bit captures the carry out of the top accumulator bit.
  assign acc_sum = {1'b0, acc_q} + (ACC_W + 1)'(product);

  // NOTE: every register, including the latched length and counter, is cleared
  // by the asynchronous reset so outputs drop to zero without a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch behind.
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;

    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          len_d   = (len == 4'd0) ? 5'd16 : {1'b0, len};
          cnt_d   = '0;
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end

      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d = acc_sum[ACC_W-1:0];
          ovf_d = ovf_q | acc_sum[ACC_W];
          cnt_d = cnt_q + 5'd1;
          if (cnt_q + 5'd1 == len_q) state_d = DONE;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        // A start on the handshake edge is dropped: IDLE only samples it next cycle.
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign sum      = acc_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator: one instance at ACC_W=12 and one at
// ACC_W=11 share stimulus so the wrap/overflow behaviour is observed on both.
module tb_product_accumulator;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  len;
  logic        in_valid;
  logic [3:0]  a;
  logic [3:0]  b;
  logic        out_ready;

  logic        in_ready,  out_valid,  overflow,  busy;
  logic [11:0] sum;
  logic        in_ready11, out_valid11, overflow11, busy11;
  logic [10:0] sum11;

  typedef struct {
    logic [11:0] s12;
    logic        o12;
    logic [10:0] s11;
    logic        o11;
  } exp_t;

  exp_t        sb_q[$];
  logic [3:0]  ta[16];
  logic [3:0]  tb_v[16];
  int          n_checks = 0;
  int          n_errors = 0;

  product_accumulator #(.ACC_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .overflow(overflow), .busy(busy)
  );

  product_accumulator #(.ACC_W(11)) dut11 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready11), .a(a), .b(b),
    .out_valid(out_valid11), .out_ready(out_ready),
    .sum(sum11), .overflow(overflow11), .busy(busy11)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pop one expected result for every accepted output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_out", sb_q.size(), 1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_sum12", sum, e.s12);
        check("sb_ovf12", overflow, e.o12);
        check("sb_valid11", out_valid11, 1);
        check("sb_sum11", sum11, e.s11);
        check("sb_ovf11", overflow11, e.o11);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_sum"}, sum, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_sum11"}, sum11, 0);
    check({tag, "_busy11"}, busy11, 0);
  endtask

  // Drive one run from ta/tb_v, push its expected result, and walk the handshake.
  task automatic do_run(input int n, input logic [3:0] len_v, input int gap_max,
                        input int hold, input bit poke);
    int   s;
    int   g;
    exp_t e;
    s = 0;
    for (int i = 0; i < n; i++) s += int'(ta[i]) * int'(tb_v[i]);
    e.s12 = 12'(s);
    e.o12 = (s > 4095);
    e.s11 = 11'(s);
    e.o11 = (s > 2047);
    sb_q.push_back(e);

    @(posedge clk); #1;
    start = 1'b1;
    len   = len_v;
    @(posedge clk); #1;
    start = 1'b0;
    len   = 4'($urandom);
    @(negedge clk);
    check("accum_busy", busy, 1);
    check("accum_in_ready", in_ready, 1);
    check("accum_out_valid", out_valid, 0);
    @(posedge clk); #1;

    for (int i = 0; i < n; i++) begin
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 1)) : 0;
      repeat (g) begin
        in_valid = 1'b0;
        a = 4'($urandom);
        b = 4'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      a = ta[i];
      b = tb_v[i];
      if (poke && i == 0) begin
        start = 1'b1;
        len   = 4'd1;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    in_valid = 1'b0;
    a = 4'($urandom);
    b = 4'($urandom);

    @(negedge clk);
    check("done_out_valid", out_valid, 1);
    check("done_in_ready", in_ready, 0);
    check("done_sum", sum, e.s12);
    check("done_ovf", overflow, e.o12);
    repeat (hold) begin
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_sum", sum, e.s12);
      check("hold_ovf", overflow, e.o12);
    end

    @(posedge clk); #1;
    out_ready = 1'b1;
    start     = poke;
    len       = 4'd2;
    @(negedge clk);
    check("handshake_valid", out_valid, 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    start     = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_out_valid", out_valid, 0);
    check("idle_in_ready", in_ready, 0);
    check("idle_sum_held", sum, e.s12);
    check("idle_ovf_held", overflow, e.o12);
    check("idle_sum11_held", sum11, e.s11);
  endtask

  task automatic load_four();
    ta[0] = 4'd0;  tb_v[0] = 4'd0;
    ta[1] = 4'd3;  tb_v[1] = 4'd2;
    ta[2] = 4'd7;  tb_v[2] = 4'd5;
    ta[3] = 4'd15; tb_v[3] = 4'd15;
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = 4'd0;
    in_valid  = 1'b0;
    a         = 4'd0;
    b         = 4'd0;
    out_ready = 1'b0;
    #2;
    check_all_zero("reset");
    #10;
    rst_n = 1'b1;

    // Single term, result visible the cycle after the transfer.
    ta[0] = 4'd3; tb_v[0] = 4'd2;
    do_run(1, 4'd1, 0, 0, 1'b0);

    load_four();
    do_run(4, 4'd4, 0, 0, 1'b0);

    // Same run with input gaps and downstream back-pressure.
    load_four();
    do_run(4, 4'd4, 3, 5, 1'b0);

    // len=0 means 16 terms; 3600 fits in 12 bits but wraps in 11.
    for (int i = 0; i < 16; i++) begin
      ta[i]   = 4'd15;
      tb_v[i] = 4'd15;
    end
    do_run(16, 4'd0, 0, 2, 1'b0);

    // Reset part-way through a four-term run.
    @(posedge clk); #1;
    start = 1'b1;
    len   = 4'd4;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    a = 4'd3;
    b = 4'd2;
    @(posedge clk); #1;
    a = 4'd7;
    b = 4'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("midrun_sum", sum, 41);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    @(negedge clk); #2;
    rst_n = 1'b1;
    ta[0] = 4'd7; tb_v[0] = 4'd5;
    do_run(1, 4'd1, 0, 0, 1'b0);

    // start pulsed during ACCUM and on the handshake edge must be ignored.
    load_four();
    do_run(4, 4'd4, 1, 1, 1'b1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("final_idle_busy", busy, 0);
    check("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
